// File: rtl/jpeg_pkg.sv
// Shared JPEG definitions for the coefficient datapath.
//   COEF_W  - signed coefficient width (in and out)
//   RECIP_W - unsigned quantiser reciprocal width, recip = round(2^16 / Q)
//   FRAC_W  - fractional bits carried by the reciprocal
//   P_W     - width of |coef| * recip
//   ZIGZAG_LUT - zigzag position -> row-major index
//   coef_t  - signed coefficient type
package jpeg_pkg;

    localparam int COEF_W  = 12;
    localparam int RECIP_W = 17;
    localparam int FRAC_W  = 16;
    localparam int P_W     = COEF_W - 1 + RECIP_W;

    typedef logic signed [COEF_W-1:0] coef_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } qz_state_t;

    localparam logic [5:0] ZIGZAG_LUT [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

endpackage

// File: rtl/quant_round_sat.sv
// Combinational quantiser back end: rounds a fixed-point magnitude
// product half-away-from-zero, drops the fraction, saturates to the
// largest positive coefficient and re-applies the sign (-0 becomes 0).
//   prod - |coef| * recip, FRAC_W fractional bits, unsigned
//   neg  - sign of the original coefficient
//   q    - signed quantised coefficient
module quant_round_sat
    import jpeg_pkg::*;
(
    input  logic [P_W-1:0] prod,
    input  logic           neg,
    output coef_t          q
);

    localparam int              M_W     = P_W + 1 - FRAC_W;
    localparam logic [P_W:0]    HALF    = (P_W + 1)'(2 ** (FRAC_W - 1));
    localparam logic [COEF_W-2:0] MAG_MAX = '1;

    logic [M_W-1:0]    m;
    logic [COEF_W-2:0] mag;

    always_comb begin
        // Rounding on the magnitude before re-signing gives
        // half-away-from-zero for both signs.
        m   = M_W'(({1'b0, prod} + HALF) >> FRAC_W);
        mag = (m > M_W'(MAG_MAX)) ? MAG_MAX : m[COEF_W-2:0];
        q   = neg ? -coef_t'({1'b0, mag}) : coef_t'({1'b0, mag});
    end

endmodule

// File: rtl/quant_zigzag.sv
// JPEG quantiser + zigzag serialiser.
// Captures one 8x8 block of signed DCT coefficients (row-major) in a single
// cycle, then streams 64 quantised coefficients in zigzag order through a
// two-stage pipeline (multiply, then round/saturate) under valid/ready.
//   clock, reset_n            - rising-edge clock, async active-low reset
//   blk_valid / blk_ready     - block handshake; blk_data[64] row-major
//   qtab_recip[64]            - reciprocal table, row-major, static per block
//   out_valid / out_ready     - output beat handshake
//   out_data, out_idx, out_last - quantised value, zigzag position, last beat
// Optional: define QUANT_NZ_COUNT_EN to add nz_count[6:0], the number of
// nonzero beats in the current block (complete on the out_last beat).
module quant_zigzag
    import jpeg_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  coef_t              blk_data   [64],
    input  logic [RECIP_W-1:0] qtab_recip [64],
    output logic               out_valid,
    input  logic               out_ready,
    output coef_t              out_data,
    output logic [5:0]         out_idx,
    output logic               out_last
`ifdef QUANT_NZ_COUNT_EN
    ,
    output logic [6:0]         nz_count
`endif
);

    qz_state_t        state_q, state_d;
    coef_t            bank_q [64];
    coef_t            bank_d [64];
    logic [5:0]       k_q, k_d;

    logic             s1_vld_q, s1_vld_d;
    logic [P_W-1:0]   p_q, p_d;
    logic             neg_q, neg_d;
    logic [5:0]       s1_idx_q, s1_idx_d;

    logic             out_valid_q, out_valid_d;
    coef_t            out_data_q, out_data_d;
    logic [5:0]       out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;

`ifdef QUANT_NZ_COUNT_EN
    logic [6:0]       nz_q, nz_d;
`endif

    logic             advance;
    logic             issue;
    logic [5:0]       zz;
    coef_t            c_sel;
    logic [COEF_W-1:0] abs_c;
    logic [RECIP_W-1:0] r_sel;
    coef_t            q_s2;

    quant_round_sat u_round_sat (
        .prod (p_q),
        .neg  (neg_q),
        .q    (q_s2)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; that is what keeps this block free of latches.
        state_d     = state_q;
        bank_d      = bank_q;
        k_d         = k_q;
        s1_vld_d    = s1_vld_q;
        p_d         = p_q;
        neg_d       = neg_q;
        s1_idx_d    = s1_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;

        // The whole pipeline moves together; it stalls only while a beat
        // sits in the output register and downstream refuses it.
        advance = !out_valid_q || out_ready;
        issue   = (state_q == ST_RUN) && advance;

        zz    = ZIGZAG_LUT[k_q];
        c_sel = bank_q[zz];
        r_sel = qtab_recip[zz];
        // Unsigned view of -c also covers the most-negative value.
        abs_c = c_sel[COEF_W-1] ? (~c_sel + 1'b1) : c_sel;

        case (state_q)
            ST_IDLE: begin
                if (blk_valid) begin
                    bank_d  = blk_data;
                    k_d     = 6'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    k_d = k_q + 6'd1;
                    if (k_q == 6'd63) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready && out_last_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            s1_vld_d = issue;
            if (issue) begin
                p_d      = {{(P_W-COEF_W){1'b0}}, abs_c} * {{(P_W-RECIP_W){1'b0}}, r_sel};
                neg_d    = c_sel[COEF_W-1];
                s1_idx_d = k_q;
            end

            out_valid_d = s1_vld_q;
            out_last_d  = s1_vld_q && (s1_idx_q == 6'd63);
            if (s1_vld_q) begin
                out_data_d = q_s2;
                out_idx_d  = s1_idx_q;
            end
        end
    end

`ifdef QUANT_NZ_COUNT_EN
    always_comb begin
        nz_d = nz_q;
        if (state_q == ST_IDLE && blk_valid) begin
            nz_d = 7'd0;
        end else if (advance && s1_vld_q && (q_s2 != '0)) begin
            nz_d = nz_q + 7'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) nz_q <= 7'd0;
        else          nz_q <= nz_d;
    end

    assign nz_count = nz_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            k_q         <= 6'd0;
            s1_vld_q    <= 1'b0;
            p_q         <= '0;
            neg_q       <= 1'b0;
            s1_idx_q    <= 6'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= 6'd0;
            out_last_q  <= 1'b0;
            // NOTE: the coefficient bank is reset too, so an aborted block
            // leaves no stale coefficients behind; a bank that is always
            // overwritten before use would not need this.
            for (int i = 0; i < 64; i++) bank_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            s1_vld_q    <= s1_vld_d;
            p_q         <= p_d;
            neg_q       <= neg_d;
            s1_idx_q    <= s1_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            bank_q      <= bank_d;
        end
    end

    assign blk_ready = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_quant_zigzag.sv
// Self-checking bench for quant_zigzag. Expected beats come from a
// reference that walks the 8x8 anti-diagonals and quantises with plain
// integer arithmetic.
module tb_quant_zigzag;
    import jpeg_pkg::*;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               blk_valid;
    logic               blk_ready;
    coef_t              blk_data   [64];
    logic [RECIP_W-1:0] qtab_recip [64];
    logic               out_valid;
    logic               out_ready;
    coef_t              out_data;
    logic [5:0]         out_idx;
    logic               out_last;
`ifdef QUANT_NZ_COUNT_EN
    logic [6:0]         nz_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int zz_ref [64];
    int exp_q  [64];

    always #5 clock = ~clock;

    quant_zigzag dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_data   (blk_data),
        .qtab_recip (qtab_recip),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last)
`ifdef QUANT_NZ_COUNT_EN
        ,
        .nz_count   (nz_count)
`endif
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int recip_of(input int q);
        return (65536 + q / 2) / q;
    endfunction

    function automatic int quant(input int c, input int r);
        int mag;
        mag = (((c < 0) ? -c : c) * r + 32768) / 65536;
        if (mag > 2047) mag = 2047;
        return (c < 0) ? -mag : mag;
    endfunction

    task automatic build_zigzag();
        int n;
        int lo;
        int hi;
        n = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz_ref[n] = r * 8 + (s - r);
                    n++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz_ref[n] = r * 8 + (s - r);
                    n++;
                end
            end
        end
    endtask

    task automatic set_recip_all(input int q);
        for (int i = 0; i < 64; i++) qtab_recip[i] = RECIP_W'(recip_of(q));
    endtask

    task automatic fill_random();
        int q;
        for (int i = 0; i < 64; i++) begin
            blk_data[i] = coef_t'(int'($urandom_range(0, 4095)) - 2048);
            q = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                            : int'($urandom_range(1, 255));
            qtab_recip[i] = RECIP_W'(recip_of(q));
        end
    endtask

    // mode 0: out_ready always 1, latency checked
    // mode 1: random backpressure, blk_valid held and data scrambled in flight
    // mode 2: 5-cycle stall while out_idx == 10
    // mode 3: reset asserted when out_idx == 30 is presented
    // exp_wait: expected idle cycles before capture (-1: not checked)
    task automatic run_block(input int mode, input int exp_wait, input string name);
        int waits;
        int cyc;
        int beat;
        int first;
        int stall;
        int nz;
        nz = 0;
        for (int b = 0; b < 64; b++) begin
            exp_q[b] = quant(int'(blk_data[zz_ref[b]]), int'(qtab_recip[zz_ref[b]]));
            if (exp_q[b] != 0) nz++;
        end

        blk_valid = 1'b1;
        waits = 0;
        while (blk_ready !== 1'b1 && waits < 10) begin
            @(negedge clock);
            waits++;
        end
        if (exp_wait >= 0) check({name, " capture wait"}, waits, exp_wait);
        else               check({name, " capture ready"}, blk_ready, 1);
        @(posedge clock);
        @(negedge clock);
        if (mode == 1) begin
            for (int i = 0; i < 64; i++) blk_data[i] = coef_t'($urandom_range(0, 4095));
        end else begin
            blk_valid = 1'b0;
        end
        check({name, " busy blk_ready"}, blk_ready, 0);

        cyc = 0; beat = 0; first = -1; stall = 0;
        while (beat < 64 && cyc < 1000) begin
            if (first >= 0) check({name, " no gap"}, out_valid, 1);
            if (out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                check({name, " idx"},  out_idx,  beat);
                check({name, " data"}, out_data, exp_q[beat]);
                check({name, " last"}, out_last, (beat == 63) ? 1 : 0);
`ifdef QUANT_NZ_COUNT_EN
                if (beat == 63) check({name, " nz_count"}, nz_count, nz);
`endif
                if (mode == 3 && beat == 30) begin
                    reset_n = 1'b0;
                    #1;
                    check({name, " rst out_valid"}, out_valid, 0);
                    check({name, " rst blk_ready"}, blk_ready, 1);
                    check({name, " rst out_idx"},   out_idx,   0);
                    check({name, " rst out_data"},  out_data,  0);
                    check({name, " rst out_last"},  out_last,  0);
                    @(negedge clock);
                    reset_n = 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clock);
                        check({name, " post-rst idle"}, out_valid, 0);
                    end
                    return;
                end
            end
            case (mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (out_valid === 1'b1 && beat == 10 && stall < 5) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
            if (out_valid === 1'b1 && out_ready) beat++;
            if (beat < 64) begin
                @(negedge clock);
                cyc++;
            end
        end
        check({name, " beats"}, beat, 64);
        if (mode == 0) check({name, " latency"}, first, 2);
        if (mode == 2) check({name, " stall cycles"}, stall, 5);
        blk_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    initial begin
        build_zigzag();
        reset_n   = 1'b0;
        blk_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) blk_data[i] = '0;
        set_recip_all(1);
        idle(2);
        check("reset out_valid", out_valid, 0);
        check("reset out_data",  out_data,  0);
        check("reset out_idx",   out_idx,   0);
        check("reset out_last",  out_last,  0);
        check("reset blk_ready", blk_ready, 1);
        reset_n = 1'b1;
        idle(2);

        // DC only
        for (int i = 0; i < 64; i++) blk_data[i] = '0;
        blk_data[0] = 12'sd800;
        set_recip_all(16);
        run_block(0, 0, "dc");
        idle(2);

        // Zigzag order with Q=1
        for (int i = 0; i < 64; i++) blk_data[i] = coef_t'(i);
        set_recip_all(1);
        run_block(0, 0, "zigzag");
        idle(1);

        // Rounding, sign and saturation corner values
        fill_random();
        blk_data[zz_ref[0]] = -12'sd24;
        blk_data[zz_ref[1]] = 12'sd24;
        blk_data[zz_ref[2]] = -12'sd8;
        blk_data[zz_ref[3]] = 12'sd7;
        blk_data[zz_ref[4]] = 12'sd2047;
        blk_data[zz_ref[5]] = -12'sd2048;
        for (int b = 0; b < 4; b++) qtab_recip[zz_ref[b]] = RECIP_W'(recip_of(16));
        qtab_recip[zz_ref[4]] = RECIP_W'(recip_of(1));
        qtab_recip[zz_ref[5]] = RECIP_W'(recip_of(1));
        run_block(1, -1, "round_sat");
        idle(1);

        // Random blocks with random backpressure
        for (int n = 0; n < 3; n++) begin
            fill_random();
            run_block(1, -1, "random");
            idle($urandom_range(0, 2));
        end

        // Directed stall at out_idx 10, then back-to-back block
        fill_random();
        run_block(2, -1, "stall");
        fill_random();
        run_block(0, 1, "back2back");
        idle(1);

        // Reset mid-block, then a fresh block from out_idx 0
        fill_random();
        run_block(3, -1, "midreset");
        fill_random();
        run_block(0, 0, "after_reset");
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/quant_zigzag.md
Name: quant_zigzag

Overview:
- Sits directly downstream of the 2D DCT stage and upstream of the entropy coder.
- Accepts one 8x8 block of signed DCT coefficients in parallel, row-major.
- Quantises each coefficient by reciprocal multiply with round-half-away-from-zero and saturation.
- Streams the 64 results out one per cycle in JPEG zigzag order, under a valid/ready handshake.

Parameters:
- COEF_W, 12, signed coefficient width in and out.
- RECIP_W, 17, unsigned reciprocal width; recip = round(2^16 / Q), Q in 1..255.
- FRAC_W, 16, fractional bits of the reciprocal.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- blk_valid  in  1  coefficient block available; held by upstream until accepted.
- blk_ready  out  1  block can be captured this cycle.
- blk_data  in  [COEF_W-1:0] x 64  unpacked array, signed coefficients, row-major (index = row*8 + col).
- qtab_recip  in  [RECIP_W-1:0] x 64  reciprocal table, row-major; static while a block is in flight.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  COEF_W  signed quantised coefficient.
- out_idx  out  6  zigzag position 0..63 of out_data.
- out_last  out  1  high with out_idx == 63.

Behaviour:
- Clock is clock; reset is reset_n, asynchronous and active-low. Reset clears everything:
  - outputs: out_valid=0, out_data=0, out_idx=0, out_last=0, blk_ready=1;
  - internal: FSM to IDLE, zigzag counter k=0, coefficient bank=0, pipeline valid bits=0.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - blk_ready=1.
  - On blk_valid && blk_ready, capture blk_data into a 64x COEF_W register bank, set k=0, go to RUN.
- RUN:
  - blk_ready=0.
  - Stage 1 selects c = bank[zz(k)] and r = qtab_recip[zz(k)], where zz is the standard JPEG zigzag-to-row-major map (0,1,8,16,9,2,3,10,...,63).
  - Stage 1 registers p = |c| * r (COEF_W-1+RECIP_W bits, unsigned), the sign of c, and k.
  - Stage 2 computes m = (p + 2^(FRAC_W-1)) >> FRAC_W, saturates m to 2^(COEF_W-1)-1, applies the sign, and registers the result into out_data / out_idx / out_last with out_valid=1.
  - When k issues 63, go to DRAIN.
- DRAIN:
  - Wait until the out_last beat is accepted (out_valid && out_ready && out_last), then go to IDLE.
  - blk_ready rises the cycle after that acceptance.
- Latency: first out_valid is 2 cycles after the block-capture edge. Sustained rate is 1 coefficient/cycle when out_ready=1. A full block occupies 66 cycles minimum, plus 1 turnaround cycle in IDLE.
- Backpressure:
  - The pipeline advances only when stage 2 is empty or out_ready=1.
  - When out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable, and stage 1 and k stall. No beat is lost or duplicated.
- blk_valid while busy is ignored; the upstream holds it.
- Negative zero: -0 is emitted as 0.
- Most-negative input -2^(COEF_W-1) with Q=1 saturates to -(2^(COEF_W-1)-1).
- Reset mid-block aborts the block immediately. No partial output appears after reset deassertion.

Optional Feature:
- Macro: QUANT_NZ_COUNT_EN.
- Defined:
  - adds output port nz_count (7 bits);
  - nz_count = number of nonzero out_data beats in the current block;
  - valid on the out_last beat, cleared at block capture.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package jpeg_pkg holds:
  - COEF_W and the RECIP_W/FRAC_W constants;
  - the 64-entry zigzag lookup constant ZIGZAG_LUT;
  - the coefficient typedef coef_t.
- One natural sub-module: quant_round_sat (stage-2 arithmetic: round, shift, saturate, re-sign), combinational, reusable by the decoder-side dequantiser check.

Test Plan:
- DC only: blk_data[0]=800, others 0, all recip=4096 (Q=16), out_ready=1 → out_data=50 at out_idx 0, 0 at idx 1..63, out_last at idx 63, first out_valid 2 cycles after capture.
- Zigzag order: blk_data[i]=i, recip=65536 (Q=1) → out_data sequence 0,1,8,16,9,2,3,10,17,24,... ending 63, with out_idx equal to the beat number.
- Rounding/sign: coefficients -24, 24, -8, 7 with Q=16 → -2, 2, -1, 0. The 7 gives 0, not -0.
- Saturation: 2047 and -2048 with Q=1 → 2047 and -2047.
- Backpressure: drop out_ready for 5 cycles while out_idx=10 → out_data/out_idx held, then 11..63 follow with no gap or loss. Back-to-back blocks with blk_valid held → second capture on the cycle after blk_ready rises.
- Reset mid-block: assert reset_n=0 at out_idx 30 → out_valid=0 and blk_ready=1 immediately. After release a new block streams from out_idx 0.
